// File: rtl/cache_assoc.sv
// N-way set-associative write-back, write-allocate cache sitting between the CPU
// load/store stage and a word-wide cs/ack memory port. Lines move one word per ack.
module cache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 8
) (
    input  logic        clock,
    input  logic        cpu_rst_n,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] storedata,
    input  logic [3:0]  write_mask,
    output logic [31:0] data_read,
    output logic        cmd_stall,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_data,
    output logic        writeMemoryEnable,
    output logic        cs,
    input  logic        ack,
    input  logic [31:0] fetchdata
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BACK      = 3'd1,
        S_BACK_DONE = 3'd2,
        S_FILL      = 3'd3,
        S_FILL_DONE = 3'd4
    } state_t;

    state_t            state_r;
    logic [31:0]       data_r  [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0]  tag_r   [WAYS][SETS];
    logic [SETS-1:0]   valid_r [WAYS];
    logic [SETS-1:0]   dirty_r [WAYS];
    logic [WAY_W-1:0]  rr_r    [SETS];

    logic [WAY_W-1:0]  victim_r;
    logic [IDX_W-1:0]  idx_r;
    logic [TAG_W-1:0]  tag_lat_r;
    logic              by_rr_r;
    logic [OFF_W-1:0]  cnt_r;

    logic [OFF_W-1:0]  off_s;
    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic              req_s;
    logic              hit_s;
    logic [WAY_W-1:0]  hit_way_s;
    logic              inv_found_s;
    logic [WAY_W-1:0]  inv_way_s;
    logic [WAY_W-1:0]  victim_s;
    logic [31:0]       hit_word_s;
    logic [OFF_W-1:0]  cnt_inc_s;
    logic              addr_unused_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [WAY_W-1:0] next_way(input logic [WAY_W-1:0] v);
        logic [WAY_W-1:0] res;
        if (v == WAY_W'(WAYS - 1)) begin
            res = '0;
        end else begin
            res = v + WAY_W'(1);
        end
        return res;
    endfunction

    assign off_s         = cpu_addr[OFF_W+1:2];
    assign idx_s         = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign tag_s         = cpu_addr[31:OFF_W+IDX_W+2];
    assign addr_unused_s = ^cpu_addr[1:0];
    assign req_s         = read_en | write_en;
    assign cnt_inc_s     = cnt_r + OFF_W'(1);
    assign hit_word_s    = data_r[hit_way_s][idx_s][off_s];
    assign victim_s      = inv_found_s ? inv_way_s : rr_r[idx_s];
    assign cmd_stall     = (state_r != S_IDLE) | (req_s & ~hit_s);

    // Hit detection and lowest-invalid-way search; descending scan so the lowest way wins
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = '0;
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_r[w][idx_s] && (tag_r[w][idx_s] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_s     = hit_s;
                hit_way_s = hit_way_s;
            end
            if (!valid_r[w][idx_s]) begin
                inv_found_s = 1'b1;
                inv_way_s   = WAY_W'(w);
            end else begin
                inv_found_s = inv_found_s;
                inv_way_s   = inv_way_s;
            end
        end
    end

    // Data and tag storage: store hits, fill beats and tag install (arrays are not reset)
    always_ff @(posedge clock) begin
        if (state_r == S_IDLE && req_s && hit_s && write_en) begin
            data_r[hit_way_s][idx_s][off_s] <= merge_bytes(hit_word_s, storedata, write_mask);
        end else if (state_r == S_FILL && ack) begin
            data_r[victim_r][idx_r][cnt_r] <= fetchdata;
        end
        if (state_r == S_FILL_DONE) begin
            tag_r[victim_r][idx_r] <= tag_lat_r;
        end
    end

    // Miss-handling FSM with line state bookkeeping and registered memory-side outputs
    always_ff @(posedge clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_r           <= S_IDLE;
            valid_r           <= '{default: '0};
            dirty_r           <= '{default: '0};
            rr_r              <= '{default: '0};
            cnt_r             <= '0;
            victim_r          <= '0;
            idx_r             <= '0;
            tag_lat_r         <= '0;
            by_rr_r           <= 1'b0;
            data_read         <= 32'h0000_0000;
            memory_addr       <= 32'h0000_0000;
            memory_data       <= 32'h0000_0000;
            cs                <= 1'b0;
            writeMemoryEnable <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_s && hit_s) begin
                        data_read <= hit_word_s;
                        if (write_en) begin
                            dirty_r[hit_way_s][idx_s] <= 1'b1;
                        end
                    end else if (req_s) begin
                        victim_r  <= victim_s;
                        idx_r     <= idx_s;
                        tag_lat_r <= tag_s;
                        by_rr_r   <= ~inv_found_s;
                        cnt_r     <= '0;
                        cs        <= 1'b1;
                        if (valid_r[victim_s][idx_s] && dirty_r[victim_s][idx_s]) begin
                            state_r           <= S_BACK;
                            writeMemoryEnable <= 1'b1;
                            memory_addr       <= {tag_r[victim_s][idx_s], idx_s, {OFF_W{1'b0}}, 2'b00};
                            memory_data       <= data_r[victim_s][idx_s][0];
                        end else begin
                            state_r           <= S_FILL;
                            writeMemoryEnable <= 1'b0;
                            memory_addr       <= {tag_s, idx_s, {OFF_W{1'b0}}, 2'b00};
                        end
                    end
                end
                S_BACK: begin
                    if (ack && cnt_r == LAST_WORD) begin
                        state_r           <= S_BACK_DONE;
                        cs                <= 1'b0;
                        writeMemoryEnable <= 1'b0;
                        cnt_r             <= '0;
                    end else if (ack) begin
                        cnt_r       <= cnt_inc_s;
                        memory_addr <= {tag_r[victim_r][idx_r], idx_r, cnt_inc_s, 2'b00};
                        memory_data <= data_r[victim_r][idx_r][cnt_inc_s];
                    end
                end
                S_BACK_DONE: begin
                    valid_r[victim_r][idx_r] <= 1'b0;
                    dirty_r[victim_r][idx_r] <= 1'b0;
                    cnt_r                    <= '0;
                    state_r                  <= S_FILL;
                    cs                       <= 1'b1;
                    writeMemoryEnable        <= 1'b0;
                    memory_addr              <= {tag_lat_r, idx_r, {OFF_W{1'b0}}, 2'b00};
                end
                S_FILL: begin
                    if (ack && cnt_r == LAST_WORD) begin
                        state_r <= S_FILL_DONE;
                        cs      <= 1'b0;
                        cnt_r   <= '0;
                    end else if (ack) begin
                        cnt_r       <= cnt_inc_s;
                        memory_addr <= {tag_lat_r, idx_r, cnt_inc_s, 2'b00};
                    end
                end
                S_FILL_DONE: begin
                    valid_r[victim_r][idx_r] <= 1'b1;
                    dirty_r[victim_r][idx_r] <= 1'b0;
                    if (by_rr_r) begin
                        rr_r[idx_r] <= next_way(victim_r);
                    end
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r           <= S_IDLE;
                    cs                <= 1'b0;
                    writeMemoryEnable <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc: a 2-way and a 4-way instance share one
// cs/ack memory responder; sel4 picks which instance is being exercised.
module tb_cache_assoc;
    logic        clock;
    logic        cpu_rst_n;
    logic        read_en, write_en;
    logic [31:0] cpu_addr, storedata;
    logic [3:0]  write_mask;
    logic        ack;
    logic [31:0] fetchdata;
    logic        sel4;
    logic        ack_always;

    logic [31:0] dr2, ma2, md2, dr4, ma4, md4;
    logic        st2, we2, cs2, st4, we4, cs4;
    logic [31:0] m_dr, m_addr, m_md;
    logic        m_stall, m_we, m_cs;

    logic [31:0] mem [1024];
    logic [31:0] bq_addr[$];
    logic [31:0] bq_data[$];
    logic        bq_we[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        last_stall;
    int          last_cyc;
    logic [31:0] last_rd;
    int          wait_cnt;

    logic [31:0] t4_addr [23];
    logic        t4_st   [23];

    cache_assoc #(.WAYS(2), .SETS(4), .LINE_WORDS(8)) u_dut2 (
        .clock(clock), .cpu_rst_n(cpu_rst_n),
        .read_en(read_en & ~sel4), .write_en(write_en & ~sel4),
        .cpu_addr(cpu_addr), .storedata(storedata), .write_mask(write_mask),
        .data_read(dr2), .cmd_stall(st2), .memory_addr(ma2), .memory_data(md2),
        .writeMemoryEnable(we2), .cs(cs2), .ack(ack & ~sel4), .fetchdata(fetchdata)
    );

    cache_assoc #(.WAYS(4), .SETS(4), .LINE_WORDS(8)) u_dut4 (
        .clock(clock), .cpu_rst_n(cpu_rst_n),
        .read_en(read_en & sel4), .write_en(write_en & sel4),
        .cpu_addr(cpu_addr), .storedata(storedata), .write_mask(write_mask),
        .data_read(dr4), .cmd_stall(st4), .memory_addr(ma4), .memory_data(md4),
        .writeMemoryEnable(we4), .cs(cs4), .ack(ack & sel4), .fetchdata(fetchdata)
    );

    assign m_dr    = sel4 ? dr4 : dr2;
    assign m_stall = sel4 ? st4 : st2;
    assign m_addr  = sel4 ? ma4 : ma2;
    assign m_md    = sel4 ? md4 : md2;
    assign m_we    = sel4 ? we4 : we2;
    assign m_cs    = sel4 ? cs4 : cs2;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic beat();
        bq_addr.push_back(m_addr);
        bq_data.push_back(m_we ? m_md : mem[m_addr[11:2]]);
        bq_we.push_back(m_we);
        if (m_we) mem[m_addr[11:2]] = m_md;
        else      fetchdata = mem[m_addr[11:2]];
    endtask

    task automatic clear_beats();
        bq_addr.delete();
        bq_data.delete();
        bq_we.delete();
    endtask

    // Memory responder: ack two cycles into each beat, or every cycle when ack_always is set
    initial begin
        ack = 1'b0;
        fetchdata = 32'h0;
        wait_cnt = 0;
        forever begin
            @(negedge clock);
            if (!cpu_rst_n) begin
                ack = 1'b0;
                wait_cnt = 0;
            end else if (ack_always) begin
                ack = 1'b1;
                if (m_cs) beat();
            end else if (ack) begin
                ack = 1'b0;
                wait_cnt = 0;
            end else if (m_cs) begin
                wait_cnt++;
                if (wait_cnt >= 2) begin
                    ack = 1'b1;
                    beat();
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic access(input logic st, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clock);
        read_en = ~st; write_en = st; cpu_addr = a; storedata = d; write_mask = m;
        #1;
        last_stall = m_stall;
        last_cyc = 0;
        while (m_stall && last_cyc < 500) begin
            @(negedge clock);
            #1;
            last_cyc++;
        end
        if (last_cyc >= 500) check_eq("stall_timeout", {31'd0, m_stall}, 32'd0);
        @(posedge clock);
        #1;
        last_rd = m_dr;
        read_en = 1'b0; write_en = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] a, input logic exp_stall);
        access(1'b0, a, 32'h0, 4'h0);
        check_eq({tag, "_stall"}, {31'd0, last_stall}, {31'd0, exp_stall});
        check_eq({tag, "_data"}, last_rd, 32'hA000_0000 + (a >> 2));
    endtask

    initial begin
        cpu_rst_n = 1'b0; read_en = 1'b0; write_en = 1'b0; cpu_addr = 32'h0;
        storedata = 32'h0; write_mask = 4'h0; sel4 = 1'b0; ack_always = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
        for (int n = 0; n < 8; n++) mem[16 + n] = 32'h0000_1000 + n;
        mem[32'h19] = 32'h1122_3344;
        t4_addr = '{32'h000, 32'h080, 32'h100, 32'h180, 32'h200, 32'h080, 32'h100, 32'h180,
                    32'h000, 32'h100, 32'h180, 32'h200, 32'h080, 32'h180, 32'h200, 32'h000,
                    32'h100, 32'h200, 32'h000, 32'h080, 32'h180, 32'h000, 32'h200};
        t4_st   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_data_read", dr2, 32'h0);
        check_eq("rst_cs", {31'd0, cs2}, 32'd0);
        check_eq("rst_we", {31'd0, we2}, 32'd0);
        check_eq("rst_maddr", ma2, 32'h0);
        check_eq("rst_mdata", md2, 32'h0);
        check_eq("rst_stall", {31'd0, st2}, 32'd0);
        @(negedge clock);
        cpu_rst_n = 1'b1;

        // Cold read miss, ack two cycles into each beat
        clear_beats();
        access(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        check_eq("t1_stall", {31'd0, last_stall}, 32'd1);
        check_eq("t1_beats", bq_addr.size(), 32'd8);
        for (int i = 0; i < 8 && i < bq_addr.size(); i++) begin
            check_eq("t1_addr", bq_addr[i], 32'h40 + 4 * i);
            check_eq("t1_we", {31'd0, bq_we[i]}, 32'd0);
        end
        check_eq("t1_data", last_rd, 32'h0000_1000);

        // Masked store hit returns pre-write value, then reload sees the merge
        access(1'b0, 32'h0000_0064, 32'h0, 4'h0);
        check_eq("t2_fill", last_rd, 32'h1122_3344);
        access(1'b1, 32'h0000_0064, 32'hAABB_CCDD, 4'b0101);
        check_eq("t2_st_stall", {31'd0, last_stall}, 32'd0);
        check_eq("t2_st_old", last_rd, 32'h1122_3344);
        access(1'b0, 32'h0000_0064, 32'h0, 4'h0);
        check_eq("t2_ld_stall", {31'd0, last_stall}, 32'd0);
        check_eq("t2_ld_data", last_rd, 32'h11BB_33DD);

        // Set-0 conflict: way0 dirty victim written back, then refilled
        load_chk("t3_a", 32'h000, 1'b1);
        access(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
        load_chk("t3_b", 32'h080, 1'b1);
        access(1'b1, 32'h0000_0088, 32'hCAFE_F00D, 4'hF);
        clear_beats();
        load_chk("t3_c", 32'h100, 1'b1);
        check_eq("t3_beats", bq_addr.size(), 32'd16);
        for (int i = 0; i < 16 && i < bq_addr.size(); i++) begin
            if (i < 8) begin
                check_eq("t3_wb_addr", bq_addr[i], 4 * i);
                check_eq("t3_wb_we", {31'd0, bq_we[i]}, 32'd1);
                check_eq("t3_wb_data", bq_data[i], (i == 1) ? 32'hDEAD_BEEF : 32'hA000_0000 + i);
            end else begin
                check_eq("t3_fill_addr", bq_addr[i], 32'h100 + 4 * (i - 8));
                check_eq("t3_fill_we", {31'd0, bq_we[i]}, 32'd0);
            end
        end
        access(1'b0, 32'h0000_0088, 32'h0, 4'h0);
        check_eq("t3_keep_stall", {31'd0, last_stall}, 32'd0);
        check_eq("t3_keep_data", last_rd, 32'hCAFE_F00D);

        // 4-way: invalid ways fill in order, then round-robin victims rotate
        sel4 = 1'b1;
        for (int i = 0; i < 23; i++) load_chk("t4", t4_addr[i], t4_st[i]);
        sel4 = 1'b0;

        // Reset asserted on the third write-back beat
        clear_beats();
        @(negedge clock);
        read_en = 1'b1; cpu_addr = 32'h0000_0180;
        for (int k = 0; k < 200 && bq_addr.size() < 3; k++) begin
            @(negedge clock);
            #1;
        end
        check_eq("t5_beats", bq_addr.size(), 32'd3);
        if (bq_addr.size() >= 3) begin
            check_eq("t5_beat3_addr", bq_addr[2], 32'h88);
            check_eq("t5_beat3_data", bq_data[2], 32'hCAFE_F00D);
        end
        cpu_rst_n = 1'b0;
        #1;
        check_eq("t5_cs", {31'd0, cs2}, 32'd0);
        check_eq("t5_we", {31'd0, we2}, 32'd0);
        check_eq("t5_maddr", ma2, 32'h0);
        check_eq("t5_dr", dr2, 32'h0);
        check_eq("t5_stall_in_rst", {31'd0, st2}, 32'd1);
        @(negedge clock);
        read_en = 1'b0;
        #1;
        cpu_rst_n = 1'b1;
        load_chk("t5_after", 32'h100, 1'b1);

        // ack held high: 10 stalled cycles per clean miss, counter wraps
        ack_always = 1'b1;
        clear_beats();
        load_chk("t6_a", 32'h060, 1'b1);
        check_eq("t6_a_cyc", last_cyc, 32'd10);
        check_eq("t6_a_beats", bq_addr.size(), 32'd8);
        clear_beats();
        load_chk("t6_b", 32'h0E0, 1'b1);
        check_eq("t6_b_cyc", last_cyc, 32'd10);
        check_eq("t6_b_beats", bq_addr.size(), 32'd8);
        if (bq_addr.size() == 8) begin
            check_eq("t6_b_first", bq_addr[0], 32'hE0);
            check_eq("t6_b_last", bq_addr[7], 32'hFC);
        end
        load_chk("t6_c", 32'h060, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_assoc.md
Name: cache_assoc

Overview:
- Parametrised N-way set-associative write-back, write-allocate cache between the CPU load/store stage and the word-wide memory port.
- Generalises the direct-mapped single-way cache with the following:
  - configurable ways, sets and line length;
  - valid-qualified hit detection;
  - per-byte write mask;
  - round-robin victim selection;
  - a combinational stall that is asserted in the same cycle as the miss.
- Line transfers use the existing cs/ack word-at-a-time memory handshake.

Parameters:
- WAYS, 2, associativity; legal values 1, 2, 4.
- SETS, 4, sets per way; power of two, ≥2.
- LINE_WORDS, 8, 32-bit words per line; power of two, ≥2.
- Derived: OFF_W=log2(LINE_WORDS), IDX_W=log2(SETS), TAG_W=30-OFF_W-IDX_W.

Ports:
- clock  in  1  rising-edge clock
- cpu_rst_n  in  1  asynchronous active-low reset
- read_en  in  1  load request
- write_en  in  1  store request
- cpu_addr  in  32  byte address; offset=[OFF_W+1:2], index=next IDX_W bits, tag=rest
- storedata  in  32  store data
- write_mask  in  4  byte enables for stores; bit i covers storedata[8i+7:8i]
- data_read  out  32  load data, registered
- cmd_stall  out  1  CPU must hold its request and stall
- memory_addr  out  32  word address to memory; [1:0] always 0
- memory_data  out  32  write-back data
- writeMemoryEnable  out  1  1 = write beat, 0 = read beat
- cs  out  1  memory request
- ack  in  1  memory beat complete, sampled on clock
- fetchdata  in  32  read data, valid when ack=1

Behaviour:
- Reset (async, cpu_rst_n=0):
  - state=S_IDLE; all valid, dirty and round-robin pointers cleared; word counter=0.
  - data_read=0, memory_addr=0, memory_data=0, cs=0, writeMemoryEnable=0.
  - Data and tag arrays are not reset.
  - Reset during a burst drops cs and writeMemoryEnable immediately and abandons the burst.
- Request definitions:
  - req = read_en|write_en. read_en and write_en together are treated as a store.
  - hit = some way w with valid[w][idx] and tag[w][idx]==addr tag. At most one way hits; the lowest index wins if not.
- cmd_stall = (state!=S_IDLE) | (req & ~hit). It is combinational and is 0 on a hit cycle.
- Hit in S_IDLE:
  - At the clock edge, data_read <= the addressed word; for a store this is the pre-write value.
  - For a store, the masked bytes are written and dirty[w][idx] is set.
  - Load-use latency is 1 cycle with no stall.
- Miss in S_IDLE: choose victim v.
  - v is the lowest invalid way; otherwise v = rr[idx].
  - Latch v and the line address.
  - If valid[v]&dirty[v], go to S_BACK; otherwise go to S_FILL. The counter is cleared.
- S_BACK:
  - cs=1, writeMemoryEnable=1.
  - memory_addr = {victim tag, idx, count, 2'b00}; memory_data = victim word[count].
  - count increments on ack.
  - On ack with count==LINE_WORDS-1, go to S_BACK_DONE.
- S_BACK_DONE (1 cycle): cs=0, writeMemoryEnable=0, dirty[v]=0, valid[v]=0, count=0, go to S_FILL.
- S_FILL:
  - cs=1, writeMemoryEnable=0.
  - memory_addr = {req tag, idx, count, 2'b00}.
  - On ack, word[count] <= fetchdata and count increments.
  - The last ack goes to S_FILL_DONE.
- S_FILL_DONE (1 cycle):
  - cs=0; tag[v][idx] <= req tag; valid=1, dirty=0.
  - If v was chosen by rr, rr[idx] <= (v+1) mod WAYS.
  - Go to S_IDLE, where the held request hits next cycle.
- Memory-side rules:
  - memory_addr and memory_data are stable while cs=1 and no ack has arrived.
  - ack is ignored while cs=0.
  - ack arriving on the same edge that cs rises is not possible, because cs is registered.
- Edge cases:
  - Request dropped mid-miss: the fill still completes and the line is installed; data_read is unchanged.
  - WAYS=1 degenerates to direct-mapped; rr is unused.
  - The line address is latched, so cpu_addr changes during a stall do not corrupt the burst. The CPU contract still requires cpu_addr to be held.

Test Plan:
1. Cold read at 0x0000_0040 (WAYS=2, SETS=4, LINE_WORDS=8). Memory returns 0x1000+n per word with ack after 2 cycles.
   -> cmd_stall=1 immediately; 8 read beats at addrs 0x40..0x5C; then data_read=0x1000 one cycle after stall clears.
2. Store 0xAABBCCDD with mask 4'b0101 to a hit word holding 0x11223344.
   -> no stall; word becomes 0x11BB33DD; dirty set; later load returns 0x11BB33DD.
3. Three tags mapping to set 0 (0x000, 0x080, 0x100), the first two dirtied before the third is accessed.
   -> way0 is evicted first: 8 write beats at 0x00..0x1C carrying the dirty data, then 8 fill beats at 0x100..0x11C; the line at 0x080 still hits.
4. Alternate misses in one set with WAYS=4.
   -> invalid ways fill 0,1,2,3 in order; then victims rotate 0,1,2,3 via rr.
5. Assert cpu_rst_n=0 on the 3rd write-back beat.
   -> cs and writeMemoryEnable are 0 the same cycle; after release, a previously valid address misses (valid cleared), cmd_stall=1.
6. Hold ack=1 permanently.
   -> each beat lasts 1 cycle; a clean miss takes 8 fill cycles + 1 done cycle + the hit cycle; the counter wraps to 0 correctly.
